// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [1:0]       div_op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // Execute stage side
  modport master (
    output start, div_op, op1, op2,
    input  busy, done, result
  );

  // Divider side
  modport slave (
    input  start, div_op, op1, op2,
    output busy, done, result
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU. One quotient bit per cycle,
// WIDTH iterations, with a fast path for divide-by-zero and signed overflow.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  div_unit_if.slave io_bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [1:0]       r_op;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_result;
  logic [CntW-1:0]  r_count;

  // Operand conditioning at the accept edge
  logic             w_signed, w_op1_neg, w_op2_neg;
  logic [WIDTH-1:0] w_op1_abs, w_op2_abs;
  logic             w_div_zero, w_ovf, w_special, w_accept, w_last;
  logic [WIDTH-1:0] w_special_res;

  assign w_signed   = ~io_bus.div_op[0];
  assign w_op1_neg  = w_signed & io_bus.op1[WIDTH-1];
  assign w_op2_neg  = w_signed & io_bus.op2[WIDTH-1];
  assign w_op1_abs  = w_op1_neg ? -io_bus.op1 : io_bus.op1;
  assign w_op2_abs  = w_op2_neg ? -io_bus.op2 : io_bus.op2;
  assign w_div_zero = (io_bus.op2 == '0);
  assign w_ovf      = w_signed & (io_bus.op1 == MinNeg) & (&io_bus.op2);
  assign w_special  = w_div_zero | w_ovf;
  assign w_accept   = (r_state == StIdle) & io_bus.start;
  assign w_last     = (r_count == CntW'(WIDTH - 1));

  // Divide-by-zero wins over overflow (overflow needs op2 = -1, so they never overlap)
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = io_bus.div_op[1] ? io_bus.op1 : '1;
    end else begin
      w_special_res = io_bus.div_op[1] ? '0 : MinNeg;
    end
  end

  // One restoring step. The shifted remainder is WIDTH+1 bits; its top bit is r_rem[MSB],
  // so the subtraction only needs the low WIDTH bits once the compare says it fits.
  logic [WIDTH-1:0] w_rem_sh_lo, w_rem_sub, w_rem_nx, w_quo_nx;
  logic             w_ge;
  logic [WIDTH-1:0] w_fin_mag, w_fin;
  logic             w_fin_neg;

  assign w_rem_sh_lo = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
  assign w_ge        = r_rem[WIDTH-1] | (w_rem_sh_lo >= r_div);
  assign w_rem_sub   = w_rem_sh_lo - r_div;
  assign w_rem_nx    = w_ge ? w_rem_sub : w_rem_sh_lo;
  assign w_quo_nx    = {r_quo[WIDTH-2:0], w_ge};
  assign w_fin_mag   = r_op[1] ? w_rem_nx : w_quo_nx;
  assign w_fin_neg   = ~r_op[0] & (r_op[1] ? r_r_neg : r_q_neg);
  assign w_fin       = w_fin_neg ? -w_fin_mag : w_fin_mag;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and status outputs
  always_comb begin
    w_state_d      = r_state;
    io_bus.busy    = (r_state != StIdle);
    io_bus.done    = (r_state == StDone);
    unique case (r_state)
      StIdle:  if (io_bus.start) w_state_d = w_special ? StDone : StCalc;
      StCalc:  if (w_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, register the final result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op     <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_dvd    <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= io_bus.div_op;
      r_q_neg <= w_op1_neg ^ w_op2_neg;
      r_r_neg <= w_op1_neg;
      r_dvd   <= w_op1_abs;
      r_div   <= w_op2_abs;
      r_rem   <= '0;
      r_quo   <= '0;
      r_count <= '0;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == StCalc) begin
      r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
      r_rem   <= w_rem_nx;
      r_quo   <= w_quo_nx;
      r_count <= r_count + 1'b1;
      if (w_last) r_result <= w_fin;
    end
  end

  assign io_bus.result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus hand-written multi-cycle sequences.
module tb_div_unit;

  localparam int unsigned WIDTH = 32;
  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  div_unit_if #(.WIDTH(WIDTH)) u_if ();

  div_unit #(.WIDTH(WIDTH)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;   // edges after the accept edge until done is visible
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!u_if.done && cyc < 64) begin
      tick();
      cyc++;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    u_if.div_op = op;
    u_if.op1    = a;
    u_if.op2    = b;
    u_if.start  = 1'b1;
    tick();
    u_if.start  = 1'b0;
  endtask

  initial begin
    int cyc;
    int done_seen;

    vecs.push_back('{OpDivu, 32'd100,        32'd7,          32'd14,         32, "divu_100_7"});
    vecs.push_back('{OpRemu, 32'd100,        32'd7,          32'd2,          32, "remu_100_7"});
    vecs.push_back('{OpDiv,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32, "div_m7_2"});
    vecs.push_back('{OpRem,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32, "rem_m7_2"});
    vecs.push_back('{OpRem,  32'd7,          32'hFFFF_FFFE,  32'd1,          32, "rem_7_m2"});
    vecs.push_back('{OpDiv,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32, "div_7_m2"});
    vecs.push_back('{OpDiv,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32, "div_m100_m7"});
    vecs.push_back('{OpRem,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32, "rem_m100_m7"});
    vecs.push_back('{OpDivu, 32'd0,          32'd5,          32'd0,          32, "divu_0_5"});
    vecs.push_back('{OpDivu, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32, "divu_max_1"});
    vecs.push_back('{OpDivu, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32, "divu_min_max"});
    vecs.push_back('{OpDiv,  32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  0,  "div_x_0"});
    vecs.push_back('{OpRemu, 32'h0000_1234,  32'd0,          32'h0000_1234,  0,  "remu_x_0"});
    vecs.push_back('{OpRem,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  0,  "rem_m5_0"});
    vecs.push_back('{OpDivu, 32'd5,          32'd0,          32'hFFFF_FFFF,  0,  "divu_5_0"});
    vecs.push_back('{OpDiv,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0,  "div_ovf"});
    vecs.push_back('{OpRem,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0,  "rem_ovf"});

    u_if.start  = 1'b0;
    u_if.div_op = 2'b00;
    u_if.op1    = '0;
    u_if.op2    = '0;

    // Reset state
    tick();
    tick();
    check("reset_busy",   {31'd0, u_if.busy}, 32'd0);
    check("reset_done",   {31'd0, u_if.done}, 32'd0);
    check("reset_result", u_if.result,        32'd0);
    rst_n = 1'b1;
    tick();

    // Vector table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy"}, {31'd0, u_if.busy}, 32'd1);
      wait_done(0, cyc);
      check({vecs[i].name, "_lat"}, cyc, vecs[i].lat);
      check({vecs[i].name, "_res"}, u_if.result, vecs[i].exp);
      tick();
      check({vecs[i].name, "_pulse"}, {30'd0, u_if.done, u_if.busy}, 32'd0);
      check({vecs[i].name, "_hold"}, u_if.result, vecs[i].exp);
    end

    // start and new operands mid-CALC are ignored
    issue(OpDivu, 32'd100, 32'd7);
    repeat (5) tick();
    u_if.div_op = OpRemu;
    u_if.op1    = 32'd1000;
    u_if.op2    = 32'd3;
    u_if.start  = 1'b1;
    repeat (3) tick();
    u_if.start  = 1'b0;
    wait_done(8, cyc);
    check("midcalc_lat", cyc, 32);
    check("midcalc_res", u_if.result, 32'd14);
    tick();
    check("midcalc_idle", {31'd0, u_if.busy}, 32'd0);

    // Reset in the middle of an operation aborts it
    issue(OpDivu, 32'd200, 32'd7);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy",   {31'd0, u_if.busy}, 32'd0);
    check("abort_done",   {31'd0, u_if.done}, 32'd0);
    check("abort_result", u_if.result,        32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (u_if.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    // Back-to-back with start held high
    u_if.div_op = OpDivu;
    u_if.op1    = 32'd100;
    u_if.op2    = 32'd7;
    u_if.start  = 1'b1;
    tick();
    u_if.op1 = 32'hFFFF_FFFF;
    u_if.op2 = 32'd1;
    wait_done(0, cyc);
    check("b2b_first_lat", cyc, 32);
    check("b2b_first_res", u_if.result, 32'd14);
    tick();
    check("b2b_gap_busy", {31'd0, u_if.busy}, 32'd0);
    tick();
    u_if.start = 1'b0;
    check("b2b_second_busy", {31'd0, u_if.busy}, 32'd1);
    check("b2b_hold_res", u_if.result, 32'd14);
    wait_done(0, cyc);
    check("b2b_second_lat", cyc, 32);
    check("b2b_second_res", u_if.result, 32'hFFFF_FFFF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
